// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_ctrl
//  Brief    : Command sequencer that turns SPI slave bytes into register
//             read/write cycles, with read prefetch and address auto-increment.
//  Revision : 1.0
// ============================================================================
module spi_reg_ctrl #(
    parameter logic [7:0]  IDLE_BYTE = 8'hA5,
    parameter int unsigned AUTO_INC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] byte_cnt
);

    localparam logic [6:0] c_addr_step = (AUTO_INC != 0) ? 7'd1 : 7'd0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_WRITE     = 3'd2,
        S_RD_FETCH  = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_RD_STREAM = 3'd5
    } state_t;

    state_t     r_state,    w_state_nxt;
    logic       r_cs_q;
    logic [6:0] r_addr,     w_addr_nxt;
    logic [6:0] r_reg_addr, w_reg_addr_nxt;
    logic [7:0] r_wdata,    w_wdata_nxt;
    logic       r_we,       w_we_nxt;
    logic       r_re,       w_re_nxt;
    logic [7:0] r_tx_byte,  w_tx_byte_nxt;
    logic       r_tx_load,  w_tx_load_nxt;
    logic [7:0] r_byte_cnt, w_byte_cnt_nxt;
    logic       r_busy;
    logic [6:0] w_addr_inc;
    logic [7:0] w_cnt_inc;

    assign w_addr_inc = r_addr + c_addr_step;
    assign w_cnt_inc  = (r_byte_cnt == 8'hFF) ? r_byte_cnt : r_byte_cnt + 8'd1;

    // All outputs are registered: next values are decided here, one cycle ahead.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_reg_addr_nxt = r_reg_addr;
        w_wdata_nxt    = r_wdata;
        w_we_nxt       = 1'b0;
        w_re_nxt       = 1'b0;
        w_tx_byte_nxt  = r_tx_byte;
        w_tx_load_nxt  = 1'b0;
        w_byte_cnt_nxt = r_byte_cnt;

        if (!cs_active) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // r_cs_q demands a fresh chip-select edge, so a frame cut by reset is not resumed.
                    if (!r_cs_q) begin
                        w_state_nxt    = S_CMD;
                        w_byte_cnt_nxt = 8'd0;
                        w_tx_byte_nxt  = IDLE_BYTE;
                        w_tx_load_nxt  = 1'b1;
                    end
                end
                S_CMD: begin
                    if (rx_valid) begin
                        w_addr_nxt     = rx_byte[6:0];
                        w_reg_addr_nxt = rx_byte[6:0];
                        if (rx_byte[7]) begin
                            w_state_nxt = S_RD_FETCH;
                            w_re_nxt    = 1'b1;
                        end else begin
                            w_state_nxt   = S_WRITE;
                            w_tx_byte_nxt = IDLE_BYTE;
                            w_tx_load_nxt = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (rx_valid) begin
                        w_we_nxt       = 1'b1;
                        w_wdata_nxt    = rx_byte;
                        w_reg_addr_nxt = r_addr;
                        w_addr_nxt     = w_addr_inc;
                        w_byte_cnt_nxt = w_cnt_inc;
                    end
                end
                S_RD_FETCH: begin
                    w_state_nxt = S_RD_WAIT;
                    if (rx_valid) w_byte_cnt_nxt = w_cnt_inc;
                end
                S_RD_WAIT: begin
                    w_state_nxt   = S_RD_STREAM;
                    w_tx_byte_nxt = reg_rdata;
                    w_tx_load_nxt = 1'b1;
                    if (rx_valid) w_byte_cnt_nxt = w_cnt_inc;
                end
                S_RD_STREAM: begin
                    if (rx_valid) begin
                        w_state_nxt    = S_RD_FETCH;
                        w_re_nxt       = 1'b1;
                        w_addr_nxt     = w_addr_inc;
                        w_reg_addr_nxt = w_addr_inc;
                        w_byte_cnt_nxt = w_cnt_inc;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cs_q     <= 1'b1;
            r_addr     <= 7'd0;
            r_reg_addr <= 7'd0;
            r_wdata    <= 8'd0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_tx_byte  <= IDLE_BYTE;
            r_tx_load  <= 1'b0;
            r_byte_cnt <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cs_q     <= cs_active;
            r_addr     <= w_addr_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_we       <= w_we_nxt;
            r_re       <= w_re_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_tx_load  <= w_tx_load_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign tx_byte   = r_tx_byte;
    assign tx_load   = r_tx_load;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = r_busy;
    assign byte_cnt  = r_byte_cnt;

endmodule
`default_nettype wire
